// File: rtl/serial_adder_if.sv
// Parallel load / parallel result handshake for the bit-serial adder.
// The master drives operands and start; the slave returns status and the result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    modport master (output start, A, B, Cin, input busy, done, Sum, Cout);
    modport slave  (input start, A, B, Cin, output busy, done, Sum, Cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first, WIDTH cycles per add.
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SHIFT | one bit summed per cycle, busy high
// DONE  | Sum/Cout valid, done pulses for one cycle
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             s;
    logic             maj;
    logic [WIDTH-1:0] nxt;

    assign s   = sa[0] ^ sb[0] ^ carry;
    assign maj = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    // Result register is one bit short: the final bit goes straight into Sum.
    assign nxt = {s, res};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa    <= bus.A;
                        sb    <= bus.B;
                        carry <= bus.Cin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry <= maj;
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    res   <= nxt[WIDTH-1:1];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_q  <= nxt;
                        cout_q <= maj;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
endmodule
